// File: rtl/boot_loader.sv
// Byte-stream boot loader: takes a big-endian word count plus image words, writes them
// into block RAM from address 0, then releases the CPU and hands the RAM port to it.
module boot_loader #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 2**SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [15:0]     cpu_data,
    output logic            ram_wrEn,
    output logic [SIZE-1:0] ram_addr,
    output logic [15:0]     ram_data,
    output logic            cpu_rst,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DAT_HI,
        DAT_LO,
        WRITE,
        RUN,
        ERR
    } state_t;

    state_t        state, stateNext;
    logic [SIZE:0] wptr, wptrNext;
    logic [15:0]   word, wordNext;
    logic [15:0]   count, countNext;
    logic          cpuRstQ;
    logic          accept;
    logic [15:0]   hdrWord;

    assign in_ready = (state == HDR_HI) || (state == HDR_LO) ||
                      (state == DAT_HI) || (state == DAT_LO);
    assign accept   = in_valid && in_ready;
    assign hdrWord  = {word[15:8], in_data};

    always_comb begin
        stateNext = state;
        wptrNext  = wptr;
        wordNext  = word;
        countNext = count;
        ram_wrEn  = 1'b0;
        ram_addr  = wptr[SIZE-1:0];
        ram_data  = 16'h0000;

        case (state)
            HDR_HI: begin
                if (accept) begin
                    wordNext[15:8] = in_data;
                    stateNext      = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    countNext = hdrWord;
                    if (hdrWord == 16'h0000)
                        stateNext = RUN;
                    else if (32'(hdrWord) > DEPTH)
                        stateNext = ERR;
                    else
                        stateNext = DAT_HI;
                end
            end
            DAT_HI: begin
                if (accept) begin
                    wordNext[15:8] = in_data;
                    stateNext      = DAT_LO;
                end
            end
            DAT_LO: begin
                if (accept) begin
                    wordNext[7:0] = in_data;
                    stateNext     = WRITE;
                end
            end
            WRITE: begin
                ram_wrEn = 1'b1;
                ram_data = word;
                wptrNext = wptr + 1'b1;
                // wptr is one bit wider than the address so N == DEPTH ends without wrapping
                if (17'(wptr) + 17'd1 == {1'b0, count})
                    stateNext = RUN;
                else
                    stateNext = DAT_HI;
            end
            RUN: begin
                // a reload request blocks the CPU write seen in the same cycle
                ram_wrEn = cpu_wrEn && !start;
                ram_addr = cpu_addr;
                ram_data = cpu_data;
            end
            ERR: begin
                stateNext = ERR;
            end
            default: begin
                stateNext = HDR_HI;
            end
        endcase

        if (start) begin
            stateNext = HDR_HI;
            wptrNext  = '0;
            wordNext  = 16'h0000;
            countNext = 16'h0000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= HDR_HI;
            wptr    <= '0;
            word    <= 16'h0000;
            count   <= 16'h0000;
            cpuRstQ <= 1'b1;
        end else begin
            state   <= stateNext;
            wptr    <= wptrNext;
            word    <= wordNext;
            count   <= countNext;
            // registered from the next state so the CPU reset never glitches on state decode
            cpuRstQ <= (stateNext != RUN);
        end
    end

    assign cpu_rst = cpuRstQ;
    assign done    = (state == RUN);
    assign err     = (state == ERR);

endmodule

// File: tb/tb_boot_loader.sv
// Directed + randomized bench for boot_loader with a word-level image model of the RAM.
module tb_boot_loader;

    localparam int SIZE  = 8;
    localparam int DEPTH = 256;

    logic            clk = 1'b0;
    logic            rstN;
    logic            start;
    logic            inValid;
    logic [7:0]      inData;
    logic            inReady;
    logic            cpuWrEn;
    logic [SIZE-1:0] cpuAddr;
    logic [15:0]     cpuData;
    logic            ramWrEn;
    logic [SIZE-1:0] ramAddr;
    logic [15:0]     ramData;
    logic            cpuRst;
    logic            done;
    logic            err;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [DEPTH];
    logic [15:0] expMem [DEPTH];
    int          wrCount = 0;
    logic        fillEn = 1'b0;

    logic [15:0] sumProg [6] = '{16'h7201, 16'h7400, 16'h7606, 16'h0488, 16'h1241, 16'h92FE};
    logic [15:0] img [$];

    boot_loader #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rstN), .start(start),
        .in_valid(inValid), .in_data(inData), .in_ready(inReady),
        .cpu_wrEn(cpuWrEn), .cpu_addr(cpuAddr), .cpu_data(cpuData),
        .ram_wrEn(ramWrEn), .ram_addr(ramAddr), .ram_data(ramData),
        .cpu_rst(cpuRst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Block RAM stand-in; fillEn seeds a known background so untouched words are visible.
    always @(posedge clk) begin
        if (fillEn) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= 16'hA500 ^ 16'(k);
        end else if (ramWrEn) begin
            mem[ramAddr] <= ramData;
            wrCount      <= wrCount + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        int t;
        inValid = 1'b0;
        repeat (gap) @(negedge clk);
        inValid = 1'b1;
        inData  = b;
        t = 0;
        while (!inReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!inReady) chk("ready_timeout", 32'(inReady), 32'd1);
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        inData  = $urandom_range(255);
    endtask

    task automatic sendWord(input logic [15:0] w, input int maxGap);
        sendByte(w[15:8], $urandom_range(maxGap));
        sendByte(w[7:0], $urandom_range(maxGap));
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int t = 0;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    // Loads img[] as a complete image and records the expected RAM contents.
    task automatic loadImage(input int maxGap);
        pulseStart();
        sendWord(16'(img.size()), maxGap);
        foreach (img[k]) sendWord(img[k], maxGap);
        for (int k = 0; k < img.size(); k++) expMem[k] = img[k];
    endtask

    task automatic checkMem(input string tag);
        int errs = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== expMem[k]) errs++;
        chk(tag, 32'(errs), 32'd0);
    endtask

    initial begin
        int wr0;
        rstN    = 1'b0;
        start   = 1'b0;
        inValid = 1'b0;
        inData  = 8'h00;
        cpuWrEn = 1'b0;
        cpuAddr = '0;
        cpuData = 16'h0000;
        for (int k = 0; k < DEPTH; k++) expMem[k] = 16'hA500 ^ 16'(k);

        @(negedge clk);
        fillEn = 1'b1;
        @(negedge clk);
        fillEn = 1'b0;
        chk("rst_cpu_rst", 32'(cpuRst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wren", 32'(ramWrEn), 32'd0);
        chk("rst_addr", 32'(ramAddr), 32'd0);
        chk("rst_data", 32'(ramData), 32'd0);
        rstN = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(inReady), 32'd1);
        chk("rst_wrcount", 32'(wrCount), 32'd0);

        // Sum program, back-to-back bytes
        img.delete();
        foreach (sumProg[k]) img.push_back(sumProg[k]);
        loadImage(0);
        waitDone("prog_done");
        chk("prog_cpu_rst", 32'(cpuRst), 32'd0);
        chk("prog_ready", 32'(inReady), 32'd0);
        chk("prog_wrcount", 32'(wrCount), 32'd6);
        checkMem("prog_mem");

        // CPU pass-through in RUN, then start blocks a same-cycle CPU write
        cpuWrEn = 1'b1;
        cpuAddr = 8'h40;
        cpuData = 16'h1234;
        #1;
        chk("pass_wren", 32'(ramWrEn), 32'd1);
        chk("pass_addr", 32'(ramAddr), 32'h40);
        chk("pass_data", 32'(ramData), 32'h1234);
        expMem[8'h40] = 16'h1234;
        @(negedge clk);
        cpuAddr = 8'h41;
        start   = 1'b1;
        #1;
        chk("start_blocks_wren", 32'(ramWrEn), 32'd0);
        @(posedge clk);
        #1;
        chk("start_cpu_rst", 32'(cpuRst), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_ready", 32'(inReady), 32'd1);
        @(negedge clk);
        start   = 1'b0;
        cpuWrEn = 1'b0;
        checkMem("pass_mem");

        // Same program with random valid gaps
        loadImage(3);
        waitDone("gap_done");
        chk("gap_cpu_rst", 32'(cpuRst), 32'd0);
        checkMem("gap_mem");

        // Random image of random length with gaps
        img.delete();
        for (int k = 0; k < 1 + $urandom_range(19); k++) img.push_back(16'($urandom));
        loadImage(2);
        waitDone("rand_done");
        checkMem("rand_mem");

        // Zero-length header
        wr0 = wrCount;
        pulseStart();
        sendByte(8'h00, 0);
        sendByte(8'h00, 0);
        waitDone("zero_done");
        chk("zero_cpu_rst", 32'(cpuRst), 32'd0);
        chk("zero_nowrite", 32'(wrCount), 32'(wr0));

        // Oversized header is a sticky error
        wr0 = wrCount;
        pulseStart();
        sendByte(8'h01, 0);
        sendByte(8'h01, 0);
        chk("err_flag", 32'(err), 32'd1);
        chk("err_cpu_rst", 32'(cpuRst), 32'd1);
        chk("err_ready", 32'(inReady), 32'd0);
        inValid = 1'b1;
        repeat (4) @(negedge clk);
        inValid = 1'b0;
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_nowrite", 32'(wrCount), 32'(wr0));
        pulseStart();
        chk("err_cleared", 32'(err), 32'd0);
        chk("err_clr_ready", 32'(inReady), 32'd1);

        // Full-depth image: last word must land at DEPTH-1, nothing wraps to 0
        img.delete();
        for (int k = 0; k < DEPTH; k++) img.push_back(16'($urandom));
        loadImage(0);
        waitDone("full_done");
        checkMem("full_mem");

        // Reset after three words of a six-word load
        img.delete();
        for (int k = 0; k < 6; k++) img.push_back(16'($urandom));
        pulseStart();
        sendWord(16'd6, 1);
        for (int k = 0; k < 3; k++) sendWord(img[k], 1);
        @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) expMem[k] = img[k];
        rstN = 1'b0;
        #1;
        chk("mid_cpu_rst", 32'(cpuRst), 32'd1);
        chk("mid_wptr", 32'(ramAddr), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkMem("mid_retained");
        img.delete();
        foreach (sumProg[k]) img.push_back(sumProg[k]);
        loadImage(3);
        waitDone("reload_done");
        checkMem("reload_mem");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
